mcu_spi_arbiter: RTL
====================

# mcu_spi_arbiter

Selects which MCU SPI link, the on-board BL616 (internal) or an M0S Dock on the m0s header (external), drives the core's MCU control interface (`mcu_sclk`/`mcu_csn`/`mcu_mosi`). It sits between the board pins and the core, and replaces the direct per-signal source mux. It synchronises both links and debounces detection of the external link. Source switches occur only at frame boundaries, so the core never sees a truncated or spliced SPI frame.

## Interface
- `SYNC_STAGES`, 2: synchroniser depth on all six link inputs (min 2).
- `DETECT_CYCLES`, 8: consecutive synchronised-low cycles of `ext_csn` that count as a valid external select.
- `GUARD_CYCLES`, 4: idle cycles driven on the outputs during a source switch.
- `REVERT_CYCLES`, 32000000: external-idle time before reverting to internal (used only with `MCU_EXT_REVERT_EN`).
- `clk32`  in  1  system clock, 32 MHz. One clock; all logic runs on its rising edge.
- `por`  in  1  reset, synchronous, active-high.
- `int_sclk`, `int_csn`, `int_mosi`  in  1 each  BL616 link.
- `ext_sclk`, `ext_csn`, `ext_mosi`  in  1 each  M0S link (m0s[3], m0s[2], m0s[1]).
- `mcu_sclk`, `mcu_csn`, `mcu_mosi`  out  1 each  selected link, registered.
- `sel_ext`  out  1  1 = external link selected.
- `switching`  out  1  high during GUARD state.

## Operation
- All six inputs pass through SYNC_STAGES flops. Every decision uses synchronised values.
- States:
  - INT: outputs follow the synchronised internal link.
  - EXT_PEND: internal link still forwarded; external detected, waiting for a boundary.
  - GUARD: outputs idle.
  - EXT: outputs follow the external link.
  - INT_PEND: external link still forwarded; revert pending.
- Detect counter (width clog2(DETECT_CYCLES+1)):
  - increments while synced `ext_csn`=0, saturating at DETECT_CYCLES;
  - clears on any synced `ext_csn`=1.
  - A low pulse shorter than DETECT_CYCLES is ignored.
- INT→EXT_PEND when the detect counter reaches DETECT_CYCLES. The detecting external frame is discarded (never forwarded); M0S firmware retries.
- EXT_PEND→GUARD on the first cycle with synced `int_csn`=1 and synced `ext_csn`=1.
- GUARD lasts exactly GUARD_CYCLES cycles.
  - Outputs: `mcu_csn`=1, `mcu_sclk`=0, `mcu_mosi`=0.
  - `switching`=1.
  - Then GUARD→EXT (or →INT when entered from INT_PEND).
- `sel_ext` changes on the cycle GUARD is entered.
- EXT is sticky unless `MCU_EXT_REVERT_EN` is defined.
- Internal-link activity while in EXT is ignored.
- Idle output pattern (csn=1, sclk=0, mosi=0) applies in reset and in GUARD.

## Timing
- Reset values (cycle after `por` sampled high):
  - `mcu_csn`=1, `mcu_sclk`=0, `mcu_mosi`=0;
  - `sel_ext`=0, `switching`=0;
  - state INT;
  - detect and revert counters 0.
- `por` mid-frame or mid-GUARD aborts immediately to the reset state. Synchroniser flops reset to idle (csn=1, others 0).
- Forwarding latency, pin to output: SYNC_STAGES+1 cycles (3 at default) for all three signals. Relative alignment is preserved.
- The link SPI clock must be ≤ clk32/4 (8 MHz). Faster rates are unsupported.
- Minimum switch time from the boundary condition: GUARD_CYCLES+1 cycles until the first forwarded edge of the new source.
- Boundary conditions:
  - Detect completing on the same cycle both csn lines are high cannot occur, since detect requires `ext_csn` low. Transitions are evaluated in state order, one per cycle.
  - If synced `int_csn` is low when detect completes, the internal frame finishes untouched before the switch.

## Configuration
- `MCU_EXT_REVERT_EN` defined:
  - In EXT, a revert counter (width clog2(REVERT_CYCLES+1)) counts cycles with synced `ext_csn`=1 and clears on `ext_csn`=0.
  - At REVERT_CYCLES: EXT→INT_PEND.
  - INT_PEND→GUARD when both csn are high, then →INT with `sel_ext`=0. This handles an unplugged dock.
  - INT_PEND returns to EXT if `ext_csn` goes low before the boundary.
- Not defined: no revert counter and no INT_PEND. EXT holds until `por`.

## Test plan
- **Reset:** `por` for 3 cycles with all inputs toggling → `mcu_csn`=1, `mcu_sclk`=0, `mcu_mosi`=0, `sel_ext`=0 from the first post-reset cycle.
- **Internal forwarding:** internal 16-bit frame at 4 MHz → output bitstream identical, delayed exactly 3 cycles; `sel_ext` stays 0.
- **Glitch rejection:** `ext_csn` low for 7 cycles, repeated 10 times → no state change, `sel_ext`=0.
- **Switch at boundary:**
  - `ext_csn` low for 20 cycles while an internal frame is active → internal frame forwarded complete.
  - After both csn are high: `switching`=1 for 4 cycles, then `sel_ext`=1.
  - Next external frame forwarded with 3-cycle latency; the detecting frame is absent on the outputs.
- **Reset mid-GUARD:** `por` asserted in the 2nd GUARD cycle → reset state next cycle, `sel_ext`=0.
- **Revert (`MCU_EXT_REVERT_EN`, REVERT_CYCLES=100):** in EXT, hold `ext_csn`=1 for 100 cycles → GUARD for 4 cycles, then `sel_ext`=0 and the internal frame is forwarded. Without the macro: `sel_ext` stays 1 indefinitely.

Source files
------------

// File: rtl/mcu_spi_arbiter.sv
`default_nettype none
// mcu_spi_arbiter - frame-safe selection of the BL616 (internal) or M0S Dock (external) MCU SPI link.
// Optional MCU_EXT_REVERT_EN: revert to internal after REVERT_CYCLES of external idle.  Rev 1.0
module mcu_spi_arbiter #(
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned DETECT_CYCLES = 8,
   parameter int unsigned GUARD_CYCLES  = 4,
   parameter int unsigned REVERT_CYCLES = 32000000
) (
   input  logic clk32,
   input  logic por,
   input  logic int_sclk,
   input  logic int_csn,
   input  logic int_mosi,
   input  logic ext_sclk,
   input  logic ext_csn,
   input  logic ext_mosi,
   output logic mcu_sclk,
   output logic mcu_csn,
   output logic mcu_mosi,
   output logic sel_ext,
   output logic switching
);
   localparam int unsigned DW = $clog2(DETECT_CYCLES + 1);
   localparam int unsigned GW = $clog2(GUARD_CYCLES + 1);
   localparam logic [DW-1:0] DET_MAX    = DW'(DETECT_CYCLES);
   localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);
   localparam logic [2:0]    IDLE3      = 3'b010;
   localparam logic [5:0]    IDLE6      = {IDLE3, IDLE3};

   if (SYNC_STAGES < 2) begin : g_chk_sync
      $error("SYNC_STAGES must be at least 2");
   end
   if (DETECT_CYCLES == 0 || GUARD_CYCLES == 0 || REVERT_CYCLES == 0) begin : g_chk_counts
      $error("DETECT_CYCLES, GUARD_CYCLES and REVERT_CYCLES must be non-zero");
   end

   typedef enum logic [2:0] {
      ST_INT      = 3'd0,
      ST_EXT_PEND = 3'd1,
      ST_GUARD    = 3'd2,
      ST_EXT      = 3'd3,
      ST_INT_PEND = 3'd4
   } state_t;

   // Link bit order is {mosi, csn, sclk}; sync word is {ext link, int link}.
   logic [5:0]    sync_q [SYNC_STAGES];
   logic [2:0]    int_link;
   logic [2:0]    ext_link;
   state_t        state_q, state_d;
   logic [DW-1:0] det_q, det_d;
   logic [GW-1:0] gcnt_q, gcnt_d;
   logic          sel_ext_q, sel_d;
   logic          sw_q, sw_d;
   logic [2:0]    out_q, out_d;

`ifdef MCU_EXT_REVERT_EN
   localparam int unsigned RW = $clog2(REVERT_CYCLES + 1);
   localparam logic [RW-1:0] REV_MAX = RW'(REVERT_CYCLES);
   logic [RW-1:0] rcnt_q, rcnt_d;
`endif

   assign int_link = sync_q[SYNC_STAGES-1][2:0];
   assign ext_link = sync_q[SYNC_STAGES-1][5:3];

   always_comb begin
      state_d = state_q;
      gcnt_d  = gcnt_q;
      sel_d   = sel_ext_q;
      det_d   = det_q;
      if (ext_link[1]) begin
         det_d = '0;
      end else if (det_q != DET_MAX) begin
         det_d = det_q + 1'b1;
      end
`ifdef MCU_EXT_REVERT_EN
      rcnt_d = '0;
      if (state_q == ST_EXT && ext_link[1]) begin
         rcnt_d = (rcnt_q == REV_MAX) ? rcnt_q : rcnt_q + 1'b1;
      end
`endif

      case (state_q)
         ST_INT: begin
            if (det_q == DET_MAX) state_d = ST_EXT_PEND;
         end
         ST_EXT_PEND: begin
            if (int_link[1] && ext_link[1]) begin
               state_d = ST_GUARD;
               gcnt_d  = '0;
               sel_d   = 1'b1;
            end
         end
         ST_GUARD: begin
            // Destination is already recorded in sel_ext, set on GUARD entry.
            if (gcnt_q == GUARD_LAST) begin
               state_d = sel_ext_q ? ST_EXT : ST_INT;
            end else begin
               gcnt_d = gcnt_q + 1'b1;
            end
         end
`ifdef MCU_EXT_REVERT_EN
         ST_EXT: begin
            if (rcnt_q == REV_MAX) state_d = ST_INT_PEND;
         end
         ST_INT_PEND: begin
            if (!ext_link[1]) begin
               state_d = ST_EXT;
            end else if (int_link[1]) begin
               state_d = ST_GUARD;
               gcnt_d  = '0;
               sel_d   = 1'b0;
            end
         end
`else
         ST_EXT: begin
            state_d = ST_EXT;
         end
`endif
         default: begin
            state_d = ST_INT;
         end
      endcase

      out_d = IDLE3;
      case (state_d)
         ST_INT, ST_EXT_PEND: out_d = int_link;
         ST_EXT, ST_INT_PEND: out_d = ext_link;
         default:             out_d = IDLE3;
      endcase
      sw_d = (state_d == ST_GUARD);
   end

   always_ff @(posedge clk32) begin
      if (por) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= IDLE6;
         state_q   <= ST_INT;
         det_q     <= '0;
         gcnt_q    <= '0;
         sel_ext_q <= 1'b0;
         sw_q      <= 1'b0;
         out_q     <= IDLE3;
`ifdef MCU_EXT_REVERT_EN
         rcnt_q    <= '0;
`endif
      end else begin
         sync_q[0] <= {ext_mosi, ext_csn, ext_sclk, int_mosi, int_csn, int_sclk};
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         state_q   <= state_d;
         det_q     <= det_d;
         gcnt_q    <= gcnt_d;
         sel_ext_q <= sel_d;
         sw_q      <= sw_d;
         out_q     <= out_d;
`ifdef MCU_EXT_REVERT_EN
         rcnt_q    <= rcnt_d;
`endif
      end
   end

   assign mcu_sclk  = out_q[0];
   assign mcu_csn   = out_q[1];
   assign mcu_mosi  = out_q[2];
   assign sel_ext   = sel_ext_q;
   assign switching = sw_q;

endmodule
`default_nettype wire
